// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: single-bus register/ALU datapath driven by a start/done micro-sequencer,
// with iterative signed MUL/DIV into HI/LO and an optional hardwired-zero R0.
module bus_datapath_seq #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   parameter bit R0_ZERO = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   output logic             busy,
   output logic             done,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             carry,
   output logic             dbz,
   output logic             illegal
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, T_Y, T_ALU, T_ITER, T_WB, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] rf_q [NREGS];
   logic [WIDTH-1:0] y_q, hi_q, lo_q, ac_q, mc_q, md_q, ac_d, mc_d, bus, alu, sra, ror, rol;
   logic [2*WIDTH-1:0] z_q, prod, md_res;
   logic [WIDTH:0] add_w, sub_w, msum, dr, ddif;
   logic [3:0] op_q;
   logic [AW-1:0] ra_q, rb_q, rc_q, src;
   logic [SW-1:0] cnt_q, sh;
   logic carry_q, dbz_q, ill_q, neg_q, is_mul, is_md;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // R0 is never written when hardwired, so reading it naturally yields its reset value 0
   function automatic logic wr_ok(input logic [AW-1:0] a);
      return !(R0_ZERO && a == '0);
   endfunction

   assign src = state_q == T_Y ? rb_q : rc_q;
   assign bus = rf_q[src];
   assign rd_data = rf_q[rd_addr];
   assign sh = bus[SW-1:0];
   assign is_mul = op_q == 4'd11;
   assign is_md = is_mul || op_q == 4'd12;
   assign add_w = {1'b0, y_q} + {1'b0, bus};
   assign sub_w = {1'b0, y_q} - {1'b0, bus};
   assign sra = $signed(y_q) >>> sh;
   assign ror = WIDTH'({y_q, y_q} >> sh);
   assign rol = WIDTH'(({y_q, y_q} << sh) >> WIDTH);
   assign alu = op_q == 4'd0  ? add_w[WIDTH-1:0] :
                op_q == 4'd1  ? sub_w[WIDTH-1:0] :
                op_q == 4'd2  ? y_q & bus :
                op_q == 4'd3  ? y_q | bus :
                op_q == 4'd4  ? y_q >> sh :
                op_q == 4'd5  ? sra :
                op_q == 4'd6  ? y_q << sh :
                op_q == 4'd7  ? ror :
                op_q == 4'd8  ? rol :
                op_q == 4'd9  ? -y_q :
                op_q == 4'd10 ? ~y_q : '0;

   // Unsigned shift-add multiply / restoring divide on magnitudes; signs are fixed on the last step
   assign msum = {1'b0, ac_q} + (mc_q[0] ? {1'b0, md_q} : '0);
   assign dr = {ac_q, mc_q[WIDTH-1]};
   assign ddif = dr - {1'b0, md_q};
   assign ac_d = is_mul ? msum[WIDTH:1] : ddif[WIDTH] ? dr[WIDTH-1:0] : ddif[WIDTH-1:0];
   assign mc_d = is_mul ? {msum[0], mc_q[WIDTH-1:1]} : {mc_q[WIDTH-2:0], ~ddif[WIDTH]};
   assign prod = {ac_d, mc_d};
   assign md_res = is_mul ? (neg_q ? -prod : prod) :
                   dbz_q  ? {y_q, {WIDTH{1'b1}}} :
                   {y_q[WIDTH-1] ? -ac_d : ac_d, neg_q ? -mc_d : mc_d};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? T_Y : IDLE;
         T_Y:     state_d = T_ALU;
         T_ALU:   state_d = is_md ? T_ITER : T_WB;
         T_ITER:  state_d = &cnt_q ? T_WB : T_ITER;
         T_WB:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = state_q != IDLE;
      done = state_q == DONE;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
         y_q <= '0;
         z_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         ac_q <= '0;
         mc_q <= '0;
         md_q <= '0;
         op_q <= '0;
         ra_q <= '0;
         rb_q <= '0;
         rc_q <= '0;
         cnt_q <= '0;
         carry_q <= 1'b0;
         dbz_q <= 1'b0;
         ill_q <= 1'b0;
         neg_q <= 1'b0;
      end else begin
         if (state_q == IDLE && load_en && wr_ok(load_addr)) rf_q[load_addr] <= load_data;
         if (state_q == IDLE && start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            dbz_q <= 1'b0;
            ill_q <= 1'b0;
         end
         if (state_q == T_Y) y_q <= bus;
         if (state_q == T_ALU) begin
            z_q <= {{WIDTH{1'b0}}, alu};
            ac_q <= '0;
            mc_q <= mag(y_q);
            md_q <= mag(bus);
            neg_q <= y_q[WIDTH-1] ^ bus[WIDTH-1];
            cnt_q <= '0;
            carry_q <= op_q == 4'd0 ? add_w[WIDTH] : op_q == 4'd1 ? sub_w[WIDTH] : carry_q;
            dbz_q <= op_q == 4'd12 && bus == '0;
            ill_q <= op_q > 4'd12;
         end
         if (state_q == T_ITER) begin
            ac_q <= ac_d;
            mc_q <= mc_d;
            cnt_q <= cnt_q + SW'(1);
            if (&cnt_q) z_q <= md_res;
         end
         if (state_q == T_WB) begin
            if (is_md) begin
               hi_q <= z_q[2*WIDTH-1:WIDTH];
               lo_q <= z_q[WIDTH-1:0];
            end else if (op_q <= 4'd10 && wr_ok(ra_q)) rf_q[ra_q] <= z_q[WIDTH-1:0];
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;
   assign carry = carry_q;
   assign dbz = dbz_q;
   assign illegal = ill_q;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq: directed and random ops against an arithmetic reference model.
module tb_bus_datapath_seq;
   localparam int W = 32;
   localparam int N = 16;
   logic clk = 1'b0, clr = 1'b1, start = 1'b0, load_en = 1'b0;
   logic [3:0] op = '0, ra = '0, rb = '0, rc = '0, load_addr = '0, rd_addr = '0;
   logic [W-1:0] load_data = '0;
   logic busy, done, carry, dbz, illegal;
   logic [W-1:0] rd_data, hi, lo;
   int total = 0, bad = 0;
   logic [W-1:0] m_rf [N];
   logic [W-1:0] m_hi, m_lo;
   logic m_carry, m_dbz, m_ill;

   bus_datapath_seq #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .busy(busy), .done(done), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo),
      .carry(carry), .dbz(dbz), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_rf[i] = '0;
      m_hi = '0;
      m_lo = '0;
      m_carry = 1'b0;
      m_dbz = 1'b0;
      m_ill = 1'b0;
   endtask

   task automatic model(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      logic [W-1:0] y, z, res;
      logic [4:0] s;
      longint p, q, r;
      y = m_rf[b];
      z = m_rf[c];
      s = z[4:0];
      res = '0;
      m_dbz = 1'b0;
      m_ill = 1'b0;
      case (o)
         4'd0: begin res = y + z; m_carry = (longint'(y) + longint'(z)) > 64'hFFFF_FFFF; end
         4'd1: begin res = y - z; m_carry = y < z; end
         4'd2: res = y & z;
         4'd3: res = y | z;
         4'd4: res = y >> s;
         4'd5: begin res = y; for (int i = 0; i < s; i++) res = {res[W-1], res[W-1:1]}; end
         4'd6: res = y << s;
         4'd7: begin res = y; for (int i = 0; i < s; i++) res = {res[0], res[W-1:1]}; end
         4'd8: begin res = y; for (int i = 0; i < s; i++) res = {res[W-2:0], res[W-1]}; end
         4'd9: res = -y;
         4'd10: res = ~y;
         4'd11: begin
            p = longint'($signed(y)) * longint'($signed(z));
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         4'd12: begin
            if (z == '0) begin
               m_hi = y;
               m_lo = '1;
               m_dbz = 1'b1;
            end else begin
               q = longint'($signed(y)) / longint'($signed(z));
               r = longint'($signed(y)) % longint'($signed(z));
               m_hi = r[31:0];
               m_lo = q[31:0];
            end
         end
         default: m_ill = 1'b1;
      endcase
      if (o <= 4'd10 && a != 4'd0) m_rf[a] = res;
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         rd_addr = 4'(i);
         #1;
         check($sformatf("r%0d", i), rd_data, m_rf[i]);
      end
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("carry", carry, m_carry);
      check("dbz", dbz, m_dbz);
      check("illegal", illegal, m_ill);
   endtask

   task automatic preload(input logic [3:0] a, input logic [W-1:0] d);
      @(negedge clk);
      load_en = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk);
      #1 load_en = 1'b0;
      if (a != 4'd0) m_rf[a] = d;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      int n;
      bit seen;
      model(o, a, b, c);
      @(negedge clk);
      start = 1'b1;
      op = o;
      ra = a;
      rb = b;
      rc = c;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy", busy, 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         seen = done;
      end
      check($sformatf("lat_op%0d", o), n, (o == 4'd11 || o == 4'd12) ? W + 3 : 3);
      @(posedge clk);
      #1;
      check("idle", {busy, done}, 0);
      check_all();
   endtask

   initial begin
      int ndone;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check_all();
      @(negedge clk) clr = 1'b0;
      preload(4'd1, 32'd7);
      preload(4'd2, 32'd5);
      run_op(4'd0, 4'd3, 4'd1, 4'd2);
      preload(4'd1, 32'hFFFF_FFFF);
      preload(4'd2, 32'd1);
      run_op(4'd0, 4'd4, 4'd1, 4'd2);
      run_op(4'd1, 4'd5, 4'd2, 4'd1);
      preload(4'd1, 32'h8000_0001);
      preload(4'd2, 32'd4);
      run_op(4'd5, 4'd6, 4'd1, 4'd2);
      run_op(4'd8, 4'd7, 4'd1, 4'd2);
      run_op(4'd4, 4'd8, 4'd1, 4'd0);
      preload(4'd1, -32'sd6);
      preload(4'd2, 32'd7);
      run_op(4'd11, 4'd9, 4'd1, 4'd2);
      preload(4'd1, -32'sd7);
      preload(4'd2, 32'd2);
      run_op(4'd12, 4'd10, 4'd1, 4'd2);
      run_op(4'd12, 4'd11, 4'd1, 4'd0);
      preload(4'd1, 32'h8000_0000);
      preload(4'd2, 32'hFFFF_FFFF);
      run_op(4'd12, 4'd12, 4'd1, 4'd2);
      run_op(4'd11, 4'd13, 4'd1, 4'd1);
      preload(4'd0, 32'h55);
      run_op(4'd0, 4'd0, 4'd0, 4'd0);
      run_op(4'd13, 4'd3, 4'd1, 4'd2);
      run_op(4'd3, 4'd3, 4'd3, 4'd2);
      repeat (50) begin
         if ($urandom_range(1) == 1) preload(4'($urandom_range(15)), 32'($urandom));
         run_op(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      end
      preload(4'd1, -32'sd6);
      preload(4'd2, 32'd7);
      @(negedge clk);
      start = 1'b1;
      op = 4'd11;
      ra = 4'd9;
      rb = 4'd1;
      rc = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 clr = 1'b1;
      #1;
      model_reset();
      check("clr_busy", busy, 0);
      check("clr_hi", hi, 0);
      check("clr_lo", lo, 0);
      rd_addr = 4'd1;
      #1 check("clr_r1", rd_data, 0);
      @(negedge clk) clr = 1'b0;
      check_all();
      preload(4'd1, 32'd3);
      preload(4'd2, 32'd4);
      model(4'd0, 4'd5, 4'd1, 4'd2);
      @(negedge clk);
      start = 1'b1;
      op = 4'd0;
      ra = 4'd5;
      rb = 4'd1;
      rc = 4'd2;
      @(posedge clk);
      #1;
      op = 4'd1;
      ra = 4'd6;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(posedge clk);
         #1 ndone += int'(done);
      end
      check("one_done", ndone, 1);
      check_all();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
